// File: rtl/edf_pkg.sv
// Shared EDF definitions: claim FSM state type and the wrap-aware deadline compare
// used by both the claim block and the controller's queue.
package edf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_CLEAR = 2'd2
    } claim_state_e;

    localparam int unsigned DlMaxW = 64;

    // a is earlier than b when the MSB of (a - b) mod 2^w is set; equal is not earlier.
    function automatic logic dl_earlier(input logic [DlMaxW-1:0] a,
                                        input logic [DlMaxW-1:0] b,
                                        input int unsigned       w);
        logic [DlMaxW-1:0] diff;
        diff = a - b;
        return diff[6'(w - 1)];
    endfunction

endpackage

// File: rtl/edf_nest_stack.sv
// In-service nesting stack of {id, deadline}; a simultaneous pop and push replaces
// the top entry so the depth is unchanged.
module edf_nest_stack #(
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned DlWidth   = 16,
    parameter int unsigned NestDepth = 4,
    parameter int unsigned DepthW    = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [IdWidth-1:0] push_id_i,
    input  logic [DlWidth-1:0] push_dl_i,
    output logic [IdWidth-1:0] top_id_o,
    output logic [DlWidth-1:0] top_dl_o,
    output logic [DepthW-1:0]  depth_o
);

    logic [IdWidth-1:0] id_q [NestDepth];
    logic [DlWidth-1:0] dl_q [NestDepth];
    logic [DepthW-1:0]  depth_q, depth_d;
    logic [DepthW-1:0]  wr_idx;
    logic               wr_en;
    logic               pop_ok;

    assign pop_ok = pop_i && (depth_q != '0);

    always_comb begin
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_idx  = depth_q;
        if (pop_ok && push_i) begin
            wr_en  = 1'b1;
            wr_idx = depth_q - DepthW'(1);
        end else if (pop_ok) begin
            depth_d = depth_q - DepthW'(1);
        end else if (push_i && (depth_q < DepthW'(NestDepth))) begin
            wr_en   = 1'b1;
            depth_d = depth_q + DepthW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q <= '0;
            for (int i = 0; i < NestDepth; i++) begin
                id_q[i] <= '0;
                dl_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            for (int i = 0; i < NestDepth; i++) begin
                if (wr_en && (wr_idx == DepthW'(i))) begin
                    id_q[i] <= push_id_i;
                    dl_q[i] <= push_dl_i;
                end
            end
        end
    end

    // Top-of-stack read; zero when empty.
    always_comb begin
        top_id_o = '0;
        top_dl_o = '0;
        for (int i = 0; i < NestDepth; i++) begin
            if (depth_q == DepthW'(i + 1)) begin
                top_id_o = id_q[i];
                top_dl_o = dl_q[i];
            end
        end
    end

    assign depth_o = depth_q;

endmodule

// File: rtl/edf_irq_claim.sv
// EDF interrupt offer/claim handshake: offers the controller's winning candidate to the
// core when it preempts the innermost in-service handler, and tracks handler nesting.
module edf_irq_claim
    import edf_pkg::*;
#(
    parameter  int unsigned NrParIrqs = 2,
    parameter  int unsigned DlWidth   = 16,
    parameter  int unsigned NestDepth = 4,
    localparam int unsigned IdWidth   = $clog2(NrParIrqs),
    localparam int unsigned DepthW    = $clog2(NestDepth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cand_valid_i,
    input  logic [IdWidth-1:0] cand_id_i,
    input  logic [DlWidth-1:0] cand_dl_i,
    output logic               irq_req_o,
    output logic [IdWidth-1:0] irq_req_id_o,
    input  logic               irq_claim_i,
    input  logic               irq_done_i,
    output logic               clear_o,
    output logic [IdWidth-1:0] clear_id_o,
    output logic               cur_valid_o,
    output logic [IdWidth-1:0] cur_id_o,
    output logic [DepthW-1:0]  depth_o,
    output logic               err_o
);

    claim_state_e       state_q, state_d;
    logic [IdWidth-1:0] offer_id_q, offer_id_d;
    logic [DlWidth-1:0] offer_dl_q, offer_dl_d;
    logic               err_q, err_d;

    logic               push, pop;
    logic [IdWidth-1:0] top_id;
    logic [DlWidth-1:0] top_dl;
    logic [DepthW-1:0]  depth;
    logic               eligible;

    assign eligible = (depth == '0) ||
                      ((depth < DepthW'(NestDepth)) &&
                       dl_earlier(DlMaxW'(cand_dl_i), DlMaxW'(top_dl), DlWidth));

    assign pop  = irq_done_i && (depth != '0);
    assign push = (state_q == ST_OFFER) && irq_claim_i;

    always_comb begin
        state_d    = state_q;
        offer_id_d = offer_id_q;
        offer_dl_d = offer_dl_q;
        err_d      = (irq_claim_i && (state_q != ST_OFFER)) ||
                     (irq_done_i && (depth == '0));
        unique case (state_q)
            ST_IDLE: begin
                if (cand_valid_i && eligible) begin
                    state_d    = ST_OFFER;
                    offer_id_d = cand_id_i;
                    offer_dl_d = cand_dl_i;
                end
            end
            // Once offered, only a missing candidate withdraws it; a claim always wins.
            ST_OFFER: begin
                if (irq_claim_i) begin
                    state_d = ST_CLEAR;
                end else if (!cand_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            offer_id_q <= '0;
            offer_dl_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            offer_id_q <= offer_id_d;
            offer_dl_q <= offer_dl_d;
            err_q      <= err_d;
        end
    end

    edf_nest_stack #(
        .IdWidth  (IdWidth),
        .DlWidth  (DlWidth),
        .NestDepth(NestDepth),
        .DepthW   (DepthW)
    ) u_stack (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push),
        .pop_i    (pop),
        .push_id_i(offer_id_q),
        .push_dl_i(offer_dl_q),
        .top_id_o (top_id),
        .top_dl_o (top_dl),
        .depth_o  (depth)
    );

    assign irq_req_o    = (state_q == ST_OFFER);
    assign irq_req_id_o = irq_req_o ? offer_id_q : '0;
    assign clear_o      = (state_q == ST_CLEAR);
    assign clear_id_o   = clear_o ? offer_id_q : '0;
    assign cur_valid_o  = (depth != '0);
    assign cur_id_o     = top_id;
    assign depth_o      = depth;
    assign err_o        = err_q;

endmodule

// File: tb/tb_edf_irq_claim.sv
// Directed bench for edf_irq_claim: a one-cycle-per-row vector table plus short
// hand-written handshake sequences.
module tb_edf_irq_claim;

    localparam int unsigned NrParIrqs = 2;
    localparam int unsigned DlWidth   = 16;
    localparam int unsigned NestDepth = 4;
    localparam int unsigned IdWidth   = 1;
    localparam int unsigned DepthW    = 3;

    logic               clk;
    logic               rst;
    logic               cand_valid;
    logic [IdWidth-1:0] cand_id;
    logic [DlWidth-1:0] cand_dl;
    logic               irq_req;
    logic [IdWidth-1:0] irq_req_id;
    logic               irq_claim;
    logic               irq_done;
    logic               clear;
    logic [IdWidth-1:0] clear_id;
    logic               cur_valid;
    logic [IdWidth-1:0] cur_id;
    logic [DepthW-1:0]  depth;
    logic               err;

    int checks = 0;
    int errors = 0;

    edf_irq_claim #(
        .NrParIrqs(NrParIrqs),
        .DlWidth  (DlWidth),
        .NestDepth(NestDepth)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cand_valid_i(cand_valid),
        .cand_id_i   (cand_id),
        .cand_dl_i   (cand_dl),
        .irq_req_o   (irq_req),
        .irq_req_id_o(irq_req_id),
        .irq_claim_i (irq_claim),
        .irq_done_i  (irq_done),
        .clear_o     (clear),
        .clear_id_o  (clear_id),
        .cur_valid_o (cur_valid),
        .cur_id_o    (cur_id),
        .depth_o     (depth),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed outputs: {req, req_id, clear, clear_id, cur_valid, cur_id, depth[2:0], err}
    typedef struct {
        logic        rst;
        logic        v;
        logic        id;
        logic [15:0] dl;
        logic        claim;
        logic        done;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] outs(input logic req, input logic rid, input logic clr,
                                        input logic cid, input logic cv, input logic cur,
                                        input logic [2:0] dep, input logic e);
        return {req, rid, clr, cid, cv, cur, dep, e};
    endfunction

    function automatic logic [9:0] dut_outs();
        return {irq_req, irq_req_id, clear, clear_id, cur_valid, cur_id, depth, err};
    endfunction

    task automatic add(input logic r, input logic v, input logic id, input logic [15:0] dl,
                       input logic c, input logic d, input logic [9:0] e);
        vec_t t;
        t.rst = r; t.v = v; t.id = id; t.dl = dl; t.claim = c; t.done = d; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic id, input logic [15:0] dl,
                         input logic c, input logic d);
        rst = r; cand_valid = v; cand_id = id; cand_dl = dl; irq_claim = c; irq_done = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the offer; an expired budget counts as a failed comparison.
    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!irq_req && n < 8) begin
            step();
            n++;
        end
        chk(name, 32'(irq_req), 32'd1);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);

        // Basic offer, claim, clear latency
        add(1, 0, 0, 16'd0,   0, 0, outs(0, 0, 0, 0, 0, 0, 3'd0, 0));
        add(0, 1, 1, 16'd100, 0, 0, outs(1, 1, 0, 0, 0, 0, 3'd0, 0));
        add(0, 1, 1, 16'd100, 1, 0, outs(0, 0, 1, 1, 1, 1, 3'd1, 0));
        add(0, 0, 0, 16'd0,   0, 0, outs(0, 0, 0, 0, 1, 1, 3'd1, 0));
        // Preemption against top dl=100; offered id held while cand_id changes
        add(0, 1, 0, 16'd150, 0, 0, outs(0, 0, 0, 0, 1, 1, 3'd1, 0));
        add(0, 1, 0, 16'd100, 0, 0, outs(0, 0, 0, 0, 1, 1, 3'd1, 0));
        add(0, 1, 0, 16'd50,  0, 0, outs(1, 0, 0, 0, 1, 1, 3'd1, 0));
        add(0, 1, 1, 16'd50,  0, 0, outs(1, 0, 0, 0, 1, 1, 3'd1, 0));
        add(0, 1, 1, 16'd50,  1, 0, outs(0, 0, 1, 0, 1, 0, 3'd2, 0));
        add(0, 0, 0, 16'd0,   0, 0, outs(0, 0, 0, 0, 1, 0, 3'd2, 0));
        // Done + claim together at depth 2
        add(0, 1, 1, 16'd40,  0, 0, outs(1, 1, 0, 0, 1, 0, 3'd2, 0));
        add(0, 1, 1, 16'd40,  1, 1, outs(0, 0, 1, 1, 1, 1, 3'd2, 0));
        add(0, 0, 0, 16'd0,   0, 0, outs(0, 0, 0, 0, 1, 1, 3'd2, 0));
        add(0, 0, 0, 16'd0,   0, 1, outs(0, 0, 0, 0, 1, 1, 3'd1, 0));
        add(0, 0, 0, 16'd0,   0, 1, outs(0, 0, 0, 0, 0, 0, 3'd0, 0));
        // Protocol errors
        add(0, 0, 0, 16'd0,   0, 1, outs(0, 0, 0, 0, 0, 0, 3'd0, 1));
        add(0, 0, 0, 16'd0,   0, 0, outs(0, 0, 0, 0, 0, 0, 3'd0, 0));
        add(0, 0, 0, 16'd0,   1, 0, outs(0, 0, 0, 0, 0, 0, 3'd0, 1));
        add(0, 0, 0, 16'd0,   0, 0, outs(0, 0, 0, 0, 0, 0, 3'd0, 0));
        // Wrap: top 0xFFF0, cand 0x0005 is later; no offer straight out of CLEAR
        add(0, 1, 0, 16'hFFF0, 0, 0, outs(1, 0, 0, 0, 0, 0, 3'd0, 0));
        add(0, 1, 0, 16'hFFF0, 1, 0, outs(0, 0, 1, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'h0005, 0, 0, outs(0, 0, 0, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'h0005, 0, 0, outs(0, 0, 0, 0, 1, 0, 3'd1, 0));
        add(0, 0, 0, 16'd0,    0, 1, outs(0, 0, 0, 0, 0, 0, 3'd0, 0));
        // Wrap: top 0x0005, cand 0xFFF0 is earlier
        add(0, 1, 0, 16'h0005, 0, 0, outs(1, 0, 0, 0, 0, 0, 3'd0, 0));
        add(0, 1, 0, 16'h0005, 1, 0, outs(0, 0, 1, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'hFFF0, 0, 0, outs(0, 0, 0, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'hFFF0, 0, 0, outs(1, 1, 0, 0, 1, 0, 3'd1, 0));
        add(0, 0, 0, 16'd0,    0, 0, outs(0, 0, 0, 0, 1, 0, 3'd1, 0));
        // Reset mid-CLEAR and reset with a pending claim
        add(0, 1, 1, 16'hFFF0, 0, 0, outs(1, 1, 0, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'hFFF0, 1, 0, outs(0, 0, 1, 1, 1, 1, 3'd2, 0));
        add(1, 0, 0, 16'd0,    0, 0, outs(0, 0, 0, 0, 0, 0, 3'd0, 0));
        add(0, 1, 1, 16'd10,   0, 0, outs(1, 1, 0, 0, 0, 0, 3'd0, 0));
        add(1, 1, 1, 16'd10,   1, 0, outs(0, 0, 0, 0, 0, 0, 3'd0, 0));
        // Fill to depth 4, full blocks, done re-opens
        add(0, 1, 0, 16'd400, 0, 0, outs(1, 0, 0, 0, 0, 0, 3'd0, 0));
        add(0, 1, 0, 16'd400, 1, 0, outs(0, 0, 1, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'd300, 0, 0, outs(0, 0, 0, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'd300, 0, 0, outs(1, 1, 0, 0, 1, 0, 3'd1, 0));
        add(0, 1, 1, 16'd300, 1, 0, outs(0, 0, 1, 1, 1, 1, 3'd2, 0));
        add(0, 1, 0, 16'd200, 0, 0, outs(0, 0, 0, 0, 1, 1, 3'd2, 0));
        add(0, 1, 0, 16'd200, 0, 0, outs(1, 0, 0, 0, 1, 1, 3'd2, 0));
        add(0, 1, 0, 16'd200, 1, 0, outs(0, 0, 1, 0, 1, 0, 3'd3, 0));
        add(0, 1, 1, 16'd100, 0, 0, outs(0, 0, 0, 0, 1, 0, 3'd3, 0));
        add(0, 1, 1, 16'd100, 0, 0, outs(1, 1, 0, 0, 1, 0, 3'd3, 0));
        add(0, 1, 1, 16'd100, 1, 0, outs(0, 0, 1, 1, 1, 1, 3'd4, 0));
        add(0, 1, 0, 16'd50,  0, 0, outs(0, 0, 0, 0, 1, 1, 3'd4, 0));
        add(0, 1, 0, 16'd50,  0, 0, outs(0, 0, 0, 0, 1, 1, 3'd4, 0));
        add(0, 1, 0, 16'd50,  0, 1, outs(0, 0, 0, 0, 1, 0, 3'd3, 0));
        add(0, 1, 0, 16'd50,  0, 0, outs(1, 0, 0, 0, 1, 0, 3'd3, 0));
        add(0, 0, 0, 16'd0,   0, 0, outs(0, 0, 0, 0, 1, 0, 3'd3, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].id, vecs[i].dl, vecs[i].claim, vecs[i].done);
            step();
            chk($sformatf("vec[%0d]", i), 32'(dut_outs()), 32'(vecs[i].exp));
        end

        // Claim in the same cycle the candidate disappears is still honoured
        drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0);
        wait_req("seq_claim_offer");
        drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        step();
        chk("seq_claim_wins_clear", 32'({clear, clear_id}), 32'({1'b1, 1'b1}));
        chk("seq_claim_wins_depth", 32'(depth), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        step();
        chk("seq_clear_one_cycle", 32'(clear), 32'd0);

        // A pop while offering does not withdraw the offer
        drive(1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0);
        wait_req("seq_pop_offer");
        drive(1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1);
        step();
        chk("seq_pop_keeps_offer", 32'({irq_req, irq_req_id, depth}), 32'({1'b1, 1'b0, 3'd0}));
        drive(1'b0, 1'b1, 1'b0, 16'd3, 1'b1, 1'b0);
        step();
        chk("seq_pop_then_claim", 32'({clear, cur_valid, cur_id, depth}),
            32'({1'b1, 1'b1, 1'b0, 3'd1}));
        drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
